// File: rtl/cache_def.sv
// Shared cache/memory interface types used by the cache controller and its memory model.
package cache_def;

  localparam int unsigned LINE_W = 128;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic              rw;     // 1 = write-back, 0 = line fill
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

endpackage

// File: rtl/dm_mem_line_store.sv
// Line storage for the main-memory model: asynchronous read, synchronous write.
module dm_mem_line_store
  import cache_def::*;
#(
  parameter int unsigned LINE_AW = 14
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LINE_AW-1:0] addr,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);

  localparam int unsigned Depth = 2 ** LINE_AW;

  // Power-up contents are zero; reset deliberately leaves them alone.
  logic [LINE_W-1:0] mem [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dm_main_mem_responder.sv
// Fixed-latency main-memory model answering line fills and write-backs from a direct-mapped cache.
module dm_main_mem_responder
  import cache_def::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINE_AW = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt,
  output logic         err_overlap
);

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  localparam bit         Lat1    = (LATENCY == 1);
  localparam logic [7:0] CntLoad = Lat1 ? 8'd0 : 8'(LATENCY - 2);

  state_e             state;
  logic [7:0]         cnt;
  logic [LINE_AW-1:0] idx_q;
  logic [LINE_W-1:0]  data_q;
  logic               rw_q;

  logic               accept;
  logic               go_respond;
  logic [LINE_AW-1:0] txn_idx;
  logic [LINE_W-1:0]  txn_data;
  logic               txn_rw;
  logic               store_we;
  logic [LINE_W-1:0]  store_rdata;
  logic               unused_addr;

  assign unused_addr = ^mem_req.addr;

  assign accept     = mem_req.valid && (state == StIdle || state == StRespond);
  assign go_respond = (state == StWait && cnt == 8'd0) || (Lat1 && accept);

  // With single-cycle latency the response is built from the live request at the accept edge.
  always_comb begin
    if (Lat1) begin
      txn_idx  = mem_req.addr[LINE_AW+3:4];
      txn_data = mem_req.data;
      txn_rw   = mem_req.rw;
    end else begin
      txn_idx  = idx_q;
      txn_data = data_q;
      txn_rw   = rw_q;
    end
  end

  // A write still pending when reset arrives must never reach the store.
  assign store_we = go_respond && txn_rw && !rst;

  dm_mem_line_store #(
    .LINE_AW(LINE_AW)
  ) u_store (
    .clk  (clk),
    .we   (store_we),
    .addr (txn_idx),
    .wdata(txn_data),
    .rdata(store_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      cnt           <= 8'd0;
      idx_q         <= '0;
      data_q        <= '0;
      rw_q          <= 1'b0;
      mem_data      <= '0;
      busy          <= 1'b0;
      rd_cnt        <= 16'd0;
      wr_cnt        <= 16'd0;
      err_overlap   <= 1'b0;
    end else begin
      case (state)
        StIdle, StRespond: begin
          if (accept) begin
            idx_q  <= mem_req.addr[LINE_AW+3:4];
            data_q <= mem_req.data;
            rw_q   <= mem_req.rw;
            if (Lat1) begin
              state <= StRespond;
            end else begin
              state <= StWait;
              cnt   <= CntLoad;
            end
          end else begin
            state <= StIdle;
          end
        end
        StWait: begin
          if (mem_req.valid) begin
            err_overlap <= 1'b1;
          end
          if (cnt == 8'd0) begin
            state <= StRespond;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= StIdle;
      endcase

      busy           <= accept || (state == StWait);
      mem_data.ready <= go_respond;

      if (go_respond) begin
        mem_data.data <= txn_rw ? txn_data : store_rdata;
        if (txn_rw) begin
          if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        end else begin
          if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_main_mem_responder.sv
// Directed bench: one LATENCY=4 instance and one LATENCY=1 instance sharing clock and reset.
module tb_dm_main_mem_responder;
  import cache_def::*;

  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
  localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D3 = 128'hCAFE_F00D_0000_0001_A5A5_5A5A_FFFF_0000;
  localparam logic [127:0] DJ = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  mem_req_type  req_a = '0;
  mem_req_type  req_b = '0;
  mem_data_type md_a, md_b;
  logic         busy_a, busy_b, err_a, err_b;
  logic [15:0]  rd_a, wr_a, rd_b, wr_b;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  dm_main_mem_responder #(.LATENCY(4), .LINE_AW(14)) u_dut_a (
    .clk(clk), .rst(rst), .mem_req(req_a), .mem_data(md_a), .busy(busy_a),
    .rd_cnt(rd_a), .wr_cnt(wr_a), .err_overlap(err_a)
  );

  dm_main_mem_responder #(.LATENCY(1), .LINE_AW(14)) u_dut_b (
    .clk(clk), .rst(rst), .mem_req(req_b), .mem_data(md_b), .busy(busy_b),
    .rd_cnt(rd_b), .wr_cnt(wr_b), .err_overlap(err_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one cycle; returns just after the sampling edge.
  task automatic issue(input bit sel, input bit rw, input logic [31:0] addr,
                       input logic [127:0] data);
    mem_req_type r;
    r.addr  = addr;
    r.data  = data;
    r.rw    = rw;
    r.valid = 1'b1;
    if (sel) req_b = r;
    else req_a = r;
    tick();
    req_a.valid = 1'b0;
    req_b.valid = 1'b0;
  endtask

  function automatic logic rdy_of(input bit sel);
    return sel ? md_b.ready : md_a.ready;
  endfunction

  function automatic logic [127:0] dat_of(input bit sel);
    return sel ? md_b.data : md_a.data;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Called in cycle N+1; ends in cycle N+lat with the response checked.
  task automatic expect_resp(input bit sel, input int lat, input logic [127:0] exp,
                             input string tag);
    for (int i = 1; i < lat; i++) begin
      check({tag, "_rdy_lo"}, 128'(rdy_of(sel)), 128'd0);
      check({tag, "_busy"}, 128'(busy_of(sel)), 128'd1);
      tick();
    end
    check({tag, "_rdy_hi"}, 128'(rdy_of(sel)), 128'd1);
    check({tag, "_data"}, dat_of(sel), exp);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 128'(md_a.ready), 128'd0);
    check("rst_data", md_a.data, 128'd0);
    check("rst_busy", 128'(busy_a), 128'd0);
    check("rst_rd", 128'(rd_a), 128'd0);
    check("rst_wr", 128'(wr_a), 128'd0);
    check("rst_err", 128'(err_a), 128'd0);

    // Fill from never-written line
    issue(0, 1'b0, 32'h0000_0040, 128'd0);
    expect_resp(0, 4, 128'd0, "rd40");
    check("rd40_rdcnt", 128'(rd_a), 128'd1);
    tick();
    check("rd40_pulse", 128'(md_a.ready), 128'd0);
    check("rd40_idle", 128'(busy_a), 128'd0);
    check("rd40_hold", md_a.data, 128'd0);

    // Write then read back the same line
    issue(0, 1'b1, 32'h0000_0040, D1);
    expect_resp(0, 4, D1, "wr40");
    check("wr40_wrcnt", 128'(wr_a), 128'd1);
    tick();
    check("wr40_hold", md_a.data, D1);
    issue(0, 1'b0, 32'h0000_0040, 128'd0);
    expect_resp(0, 4, D1, "rb40");
    check("rb40_rdcnt", 128'(rd_a), 128'd2);

    // Write-back followed by fill requested in its ready cycle
    tick();
    issue(0, 1'b1, 32'h0000_1230, D2);
    expect_resp(0, 4, D2, "wb1230");
    check("wb1230_busy", 128'(busy_a), 128'd1);
    issue(0, 1'b0, 32'h0000_2230, 128'd0);
    expect_resp(0, 4, 128'd0, "fill2230");
    check("b2b_busy", 128'(busy_a), 128'd1);
    check("b2b_wrcnt", 128'(wr_a), 128'd2);
    check("b2b_rdcnt", 128'(rd_a), 128'd3);

    // Request during WAIT is ignored but flagged
    tick();
    check("pre_ovl_idle", 128'(busy_a), 128'd0);
    issue(0, 1'b0, 32'h0000_1230, 128'd0);
    check("ovl_n1_rdy", 128'(md_a.ready), 128'd0);
    issue(0, 1'b1, 32'h0000_0040, DJ);
    check("ovl_err", 128'(err_a), 128'd1);
    check("ovl_n2_rdy", 128'(md_a.ready), 128'd0);
    tick();
    check("ovl_n3_rdy", 128'(md_a.ready), 128'd0);
    tick();
    check("ovl_n4_rdy", 128'(md_a.ready), 128'd1);
    check("ovl_n4_data", md_a.data, D2);
    tick();
    check("ovl_no_extra", 128'(md_a.ready), 128'd0);
    check("ovl_no_extra_busy", 128'(busy_a), 128'd0);
    issue(0, 1'b0, 32'h0000_0040, 128'd0);
    expect_resp(0, 4, D1, "ovl_intact");
    check("ovl_rdcnt", 128'(rd_a), 128'd5);
    check("ovl_wrcnt", 128'(wr_a), 128'd2);
    check("ovl_sticky", 128'(err_a), 128'd1);

    // Reset two cycles into a write aborts it
    tick();
    issue(0, 1'b1, 32'h0000_0080, DJ);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_err", 128'(err_a), 128'd0);
    check("abort_busy", 128'(busy_a), 128'd0);
    check("abort_wr", 128'(wr_a), 128'd0);
    check("abort_rd", 128'(rd_a), 128'd0);
    check("abort_data", md_a.data, 128'd0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_rdy", 128'(md_a.ready), 128'd0);
      tick();
    end
    issue(0, 1'b0, 32'h0000_0080, 128'd0);
    expect_resp(0, 4, 128'd0, "rd80");
    check("rd80_rdcnt", 128'(rd_a), 128'd1);
    tick();

    // Valid coincident with reset is dropped
    rst = 1'b1;
    issue(0, 1'b1, 32'h0000_0040, DJ);
    rst = 1'b0;
    check("rstv_busy", 128'(busy_a), 128'd0);
    for (int i = 0; i < 5; i++) begin
      check("rstv_no_rdy", 128'(md_a.ready), 128'd0);
      tick();
    end
    issue(0, 1'b0, 32'h0000_0040, 128'd0);
    expect_resp(0, 4, D1, "rstv_intact");

    // LATENCY=1 instance with address aliasing
    issue(1, 1'b1, 32'h0004_0050, D3);
    expect_resp(1, 1, D3, "l1_wr");
    check("l1_wrcnt", 128'(wr_b), 128'd1);
    tick();
    check("l1_pulse", 128'(md_b.ready), 128'd0);
    check("l1_hold", md_b.data, D3);
    issue(1, 1'b0, 32'h0000_0050, 128'd0);
    expect_resp(1, 1, D3, "l1_alias");
    check("l1_rdcnt", 128'(rd_b), 128'd1);
    tick();
    check("l1_idle", 128'(busy_b), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
